// File: rtl/cpu10_pkg.sv
// rtl/cpu10_pkg.sv - shared widths and index type for the 10-bit register file
package cpu10_pkg;

  localparam int DATA_W   = 10;
  localparam int ADDR_W   = 2;
  localparam int NUM_REGS = 4;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one combinational register read with same-cycle write forwarding
module regfile_read_port #(
  parameter int DATA_W   = cpu10_pkg::DATA_W,
  parameter int NUM_REGS = cpu10_pkg::NUM_REGS,
  parameter int ADDR_W   = cpu10_pkg::ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic [NUM_REGS*DATA_W-1:0] i_regs_flat,
  input  logic [ADDR_W-1:0]          i_rd_addr,
  input  logic                       i_wr_en,
  input  logic [ADDR_W-1:0]          i_wr_addr,
  input  logic [DATA_W-1:0]          i_wr_data,
  output logic [DATA_W-1:0]          o_rd_data
);

  logic w_is_zero;
  logic w_fwd;

  assign w_is_zero = (ZERO_REG != 0) && (i_rd_addr == '0);
  assign w_fwd     = i_wr_en && (i_wr_addr == i_rd_addr);

  // Register 0 wins over forwarding so a discarded write never leaks out.
  always_comb begin
    o_rd_data = i_regs_flat[i_rd_addr*DATA_W +: DATA_W];
    if (w_is_zero) begin
      o_rd_data = '0;
    end else if (w_fwd) begin
      o_rd_data = i_wr_data;
    end
  end

endmodule

// File: rtl/regfile_read_10bit.sv
// rtl/regfile_read_10bit.sv - 4x10 register file with a registered two-operand read response
module regfile_read_10bit #(
  parameter int DATA_W   = cpu10_pkg::DATA_W,
  parameter int NUM_REGS = cpu10_pkg::NUM_REGS,
  parameter int ADDR_W   = cpu10_pkg::ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data
);

  logic [DATA_W-1:0]          r_regs [NUM_REGS];
  logic                       r_rsp_valid;
  logic [DATA_W-1:0]          r_rs1_data;
  logic [DATA_W-1:0]          r_rs2_data;
  logic [NUM_REGS*DATA_W-1:0] w_regs_flat;
  logic [DATA_W-1:0]          w_rs1_rd;
  logic [DATA_W-1:0]          w_rs2_rd;
  logic                       w_accept;
  logic                       w_wr_ok;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign w_regs_flat[g*DATA_W +: DATA_W] = r_regs[g];
  end

  assign req_ready = !r_rsp_valid || rsp_ready;
  assign w_accept  = req_valid && req_ready;
  assign w_wr_ok   = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  regfile_read_port #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_rs1_port (
    .i_regs_flat(w_regs_flat),
    .i_rd_addr  (rs1_addr),
    .i_wr_en    (wr_en),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .o_rd_data  (w_rs1_rd)
  );

  regfile_read_port #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_rs2_port (
    .i_regs_flat(w_regs_flat),
    .i_rd_addr  (rs2_addr),
    .i_wr_en    (wr_en),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .o_rd_data  (w_rs2_rd)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_rsp_valid <= 1'b0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
    end else begin
      if (w_wr_ok) begin
        r_regs[wr_addr] <= wr_data;
      end
      // Operands are only loaded on accept, so a stalled response stays frozen.
      if (w_accept) begin
        r_rsp_valid <= 1'b1;
        r_rs1_data  <= w_rs1_rd;
        r_rs2_data  <= w_rs2_rd;
      end else if (rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rs1_data  = r_rs1_data;
  assign rs2_data  = r_rs2_data;

endmodule

// File: tb/tb_regfile_read_10bit.sv
// tb/tb_regfile_read_10bit.sv - vector table plus scoreboard bench for regfile_read_10bit
module tb_regfile_read_10bit;

  logic       CLK;
  logic       RST_N;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [9:0] wr_data;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] rs1_addr;
  logic [1:0] rs2_addr;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [9:0] rs1_data;
  logic [9:0] rs2_data;

  regfile_read_10bit dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       we;
    logic [1:0] wa;
    logic [9:0] wd;
    logic       rv;
    logic [1:0] a1;
    logic [1:0] a2;
    logic       rr;
    logic [9:0] e1;
    logic [9:0] e2;
  } vec_t;

  typedef struct {
    logic [9:0] d1;
    logic [9:0] d2;
  } rsp_t;

  vec_t       vecs [12];
  rsp_t       exp_q [$];
  logic [9:0] m_regs [4];
  logic       m_valid;
  int         n_tests;
  int         n_fail;
  int         n_rsp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] fwd(input logic [1:0] a, input logic we, input logic [1:0] wa,
                                     input logic [9:0] wd);
    if (a == 2'd0) return 10'd0;
    if (we && wa == a) return wd;
    return m_regs[a];
  endfunction

  // One clock: drive, check at negedge against the model, advance the model, step past posedge.
  task automatic step(input logic rst_n, input logic we, input logic [1:0] wa, input logic [9:0] wd,
                      input logic rv, input logic [1:0] a1, input logic [1:0] a2, input logic rr,
                      input logic use_e, input logic [9:0] e1, input logic [9:0] e2);
    rsp_t r;
    logic exp_ready;
    RST_N = rst_n; wr_en = we; wr_addr = wa; wr_data = wd;
    req_valid = rv; rs1_addr = a1; rs2_addr = a2; rsp_ready = rr;
    @(negedge CLK);
    exp_ready = !m_valid || rr;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
      end else begin
        check("rs1_data", 32'(rs1_data), 32'(exp_q[0].d1));
        check("rs2_data", 32'(rs2_data), 32'(exp_q[0].d2));
        if (rr && rst_n) begin
          void'(exp_q.pop_front());
          n_rsp++;
        end
      end
    end
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_regs[i] = 10'd0;
      m_valid = 1'b0;
      exp_q.delete();
    end else begin
      if (rv && exp_ready) begin
        if (use_e) begin
          r.d1 = e1; r.d2 = e2;
        end else begin
          r.d1 = fwd(a1, we, wa, wd); r.d2 = fwd(a2, we, wa, wd);
        end
        exp_q.push_back(r);
        m_valid = 1'b1;
      end else if (rr) begin
        m_valid = 1'b0;
      end
      if (we && wa != 2'd0) m_regs[wa] = wd;
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int rsp_before;
    n_tests = 0; n_fail = 0; n_rsp = 0;
    m_valid = 1'b0;
    for (int i = 0; i < 4; i++) m_regs[i] = 10'd0;
    RST_N = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 10'd0;
    req_valid = 1'b0; rs1_addr = 2'd0; rs2_addr = 2'd0; rsp_ready = 1'b1;

    //        we    wa     wd        rv    a1     a2     rr    e1        e2
    vecs[0]  = '{1'b0, 2'd0, 10'h000, 1'b1, 2'd1, 2'd2, 1'b1, 10'h000, 10'h000};
    vecs[1]  = '{1'b1, 2'd2, 10'h2A5, 1'b0, 2'd0, 2'd0, 1'b1, 10'h000, 10'h000};
    vecs[2]  = '{1'b0, 2'd0, 10'h000, 1'b1, 2'd2, 2'd3, 1'b1, 10'h2A5, 10'h000};
    vecs[3]  = '{1'b1, 2'd3, 10'h155, 1'b1, 2'd3, 2'd3, 1'b1, 10'h155, 10'h155};
    vecs[4]  = '{1'b1, 2'd0, 10'h3FF, 1'b1, 2'd0, 2'd0, 1'b1, 10'h000, 10'h000};
    vecs[5]  = '{1'b0, 2'd0, 10'h000, 1'b1, 2'd0, 2'd3, 1'b1, 10'h000, 10'h155};
    vecs[6]  = '{1'b1, 2'd1, 10'h001, 1'b0, 2'd0, 2'd0, 1'b1, 10'h000, 10'h000};
    vecs[7]  = '{1'b0, 2'd0, 10'h000, 1'b1, 2'd1, 2'd2, 1'b0, 10'h001, 10'h2A5};
    vecs[8]  = '{1'b1, 2'd1, 10'h3FF, 1'b1, 2'd1, 2'd1, 1'b0, 10'h000, 10'h000};
    vecs[9]  = '{1'b0, 2'd0, 10'h000, 1'b0, 2'd0, 2'd0, 1'b0, 10'h000, 10'h000};
    vecs[10] = '{1'b0, 2'd0, 10'h000, 1'b1, 2'd1, 2'd2, 1'b1, 10'h3FF, 10'h2A5};
    vecs[11] = '{1'b0, 2'd0, 10'h000, 1'b0, 2'd0, 2'd0, 1'b1, 10'h000, 10'h000};

    @(posedge CLK);
    #1;
    // Writes and requests during reset must be ignored.
    step(1'b0, 1'b1, 2'd1, 10'h3FF, 1'b1, 2'd1, 2'd1, 1'b1, 1'b0, 10'h0, 10'h0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rs1_data", 32'(rs1_data), 32'd0);
    check("reset_rs2_data", 32'(rs2_data), 32'd0);

    for (int i = 0; i < 12; i++) begin
      step(1'b1, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].rv, vecs[i].a1, vecs[i].a2,
           vecs[i].rr, 1'b1, vecs[i].e1, vecs[i].e2);
    end

    rsp_before = n_rsp;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 2'($urandom_range(0, 3)), 10'($urandom), 1'b1,
           (i % 2 == 0) ? 2'd1 : 2'd2, (i % 2 == 0) ? 2'd3 : 2'd0, 1'b1, 1'b0, 10'h0, 10'h0);
    end
    step(1'b1, 1'b0, 2'd0, 10'h0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 10'h0, 10'h0);
    check("stream_responses", 32'(n_rsp - rsp_before), 32'd8);

    step(1'b1, 1'b1, 2'd2, 10'h123, 1'b1, 2'd2, 2'd3, 1'b0, 1'b0, 10'h0, 10'h0);
    step(1'b0, 1'b0, 2'd0, 10'h0, 1'b1, 2'd2, 2'd3, 1'b0, 1'b0, 10'h0, 10'h0);
    check("midstall_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midstall_rs1_data", 32'(rs1_data), 32'd0);
    check("midstall_rs2_data", 32'(rs2_data), 32'd0);
    step(1'b1, 1'b0, 2'd0, 10'h0, 1'b1, 2'd1, 2'd2, 1'b1, 1'b1, 10'h000, 10'h000);
    step(1'b1, 1'b0, 2'd0, 10'h0, 1'b1, 2'd3, 2'd0, 1'b1, 1'b1, 10'h000, 10'h000);
    step(1'b1, 1'b0, 2'd0, 10'h0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 10'h0, 10'h0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
